uc_channel_arbiter: RTL and testbench

Shares the single 16-bit MBED SPI link among several per-channel sample FIFOs. Paced by a free-running tick, it round-robins over the non-empty channels, launches one SPI word per grant, waits for the SPI master's FIN edge, then pops the FIFO. A burst/gap limiter caps the data rate the microcontroller must absorb. Sits between the channel FIFOs and the `SPI_MASTER_UC` instance, replacing the single-channel enable logic.

---
 rtl/uc_pkg.sv | 14 +
 rtl/uc_channel_arbiter_if.sv | 30 +++
 rtl/uc_rr_picker.sv | 26 ++
 rtl/uc_channel_arbiter.sv | 157 +++++++++++++++
 tb/tb_uc_channel_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared types and constants for the uc channel arbiter
package uc_pkg;

  localparam int WORD_W = 16;
  localparam int GAP_CYCLES_DEF = 75000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_POP  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/uc_channel_arbiter_if.sv
// rtl/uc_channel_arbiter_if.sv - channel FIFO and SPI master signal bundle for the arbiter
interface uc_channel_arbiter_if #(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2
);

  logic                             ON;
  logic [NUM_CH-1:0]                CH_EMPTY;
  logic [NUM_CH*uc_pkg::WORD_W-1:0] CH_DATA;
  logic [NUM_CH-1:0]                CH_RDREQ;
  logic                             SPI_ENA;
  logic [uc_pkg::WORD_W-1:0]        SPI_DATA;
  logic                             SPI_FIN;
  logic [CH_BITS-1:0]               GRANT_CH;
  logic                             BUSY;
  logic                             WORD_DONE;

  // arbiter side
  modport master (
    input  ON, CH_EMPTY, CH_DATA, SPI_FIN,
    output CH_RDREQ, SPI_ENA, SPI_DATA, GRANT_CH, BUSY, WORD_DONE
  );

  // FIFO / SPI master / control side
  modport slave (
    output ON, CH_EMPTY, CH_DATA, SPI_FIN,
    input  CH_RDREQ, SPI_ENA, SPI_DATA, GRANT_CH, BUSY, WORD_DONE
  );

endinterface

// File: rtl/uc_rr_picker.sv
// rtl/uc_rr_picker.sv - combinational round-robin selector starting after the last served channel
module uc_rr_picker
  import uc_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2
) (
  input  logic [NUM_CH-1:0]  req,
  input  logic [CH_BITS-1:0] last,
  output logic [CH_BITS-1:0] idx,
  output logic               valid
);

  // scan last+1 .. last+NUM_CH (mod NUM_CH); the final step revisits last itself
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!valid && req[(int'(last) + k) % NUM_CH]) begin
        valid = 1'b1;
        idx   = CH_BITS'((int'(last) + k) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/uc_channel_arbiter.sv
// rtl/uc_channel_arbiter.sv - paced round-robin arbiter feeding one SPI master from several FIFOs (option: UC_ARB_TAG_EN)
module uc_channel_arbiter
  import uc_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CH_BITS    = 2,
  parameter int TICK_BITS  = 8,
  parameter int BURST_LEN  = 3,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int GAP_BITS   = 17
) (
  input logic                 SYS_CLK,
  input logic                 RST,
  uc_channel_arbiter_if.master bus
);

  localparam int BURST_W = $clog2(BURST_LEN + 1);

  logic [TICK_BITS-1:0] tick_cnt;
  logic                 msb_prev;
  logic                 tick;

  state_t               state;
  logic                 fin_prev;
  logic                 fin_rise;
  logic                 spi_ena;
  logic [WORD_W-1:0]    spi_data;
  logic [NUM_CH-1:0]    ch_rdreq;
  logic [CH_BITS-1:0]   grant_ch;
  logic                 busy;
  logic                 word_done;
  logic [CH_BITS-1:0]   last;
  logic [BURST_W-1:0]   burst_cnt;
  logic [GAP_BITS-1:0]  gap_cnt;

  logic [NUM_CH-1:0]    req;
  logic [CH_BITS-1:0]   pick_idx;
  logic                 pick_valid;
  logic [WORD_W-1:0]    pick_word;
  logic [WORD_W-1:0]    launch_word;
  logic [NUM_CH-1:0]    grant_onehot;

  assign tick         = tick_cnt[TICK_BITS-1] & ~msb_prev;
  assign fin_rise     = bus.SPI_FIN & ~fin_prev;
  assign req          = ~bus.CH_EMPTY;
  assign pick_word    = bus.CH_DATA[pick_idx*WORD_W +: WORD_W];
  assign grant_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_ch;

`ifdef UC_ARB_TAG_EN
  assign launch_word = {pick_idx, pick_word[WORD_W-1-CH_BITS:0]};
`else
  assign launch_word = pick_word;
`endif

  uc_rr_picker #(
    .NUM_CH  (NUM_CH),
    .CH_BITS (CH_BITS)
  ) u_picker (
    .req   (req),
    .last  (last),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // free-running pacing counter, held at zero while disabled; tick fires on its MSB rising
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      tick_cnt <= '0;
      msb_prev <= 1'b0;
    end else begin
      msb_prev <= tick_cnt[TICK_BITS-1];
      if (!bus.ON) tick_cnt <= '0;
      else         tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // grant / transfer / pop / gap sequencing with all outputs registered
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      fin_prev  <= 1'b0;
      spi_ena   <= 1'b0;
      spi_data  <= '0;
      ch_rdreq  <= '0;
      grant_ch  <= '0;
      busy      <= 1'b0;
      word_done <= 1'b0;
      last      <= CH_BITS'(NUM_CH - 1);
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      fin_prev  <= bus.SPI_FIN;
      ch_rdreq  <= '0;
      word_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.ON) begin
            burst_cnt <= '0;
            gap_cnt   <= '0;
          end else if (tick && !bus.SPI_FIN && pick_valid) begin
            state    <= ST_SEND;
            spi_ena  <= 1'b1;
            busy     <= 1'b1;
            spi_data <= launch_word;
            grant_ch <= pick_idx;
          end
        end
        ST_SEND: begin
          // ON is deliberately ignored here so a started word always completes
          if (fin_rise) begin
            state     <= ST_POP;
            spi_ena   <= 1'b0;
            busy      <= 1'b0;
            ch_rdreq  <= grant_onehot;
            word_done <= 1'b1;
            last      <= grant_ch;
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        ST_POP: begin
          if (!bus.ON) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            gap_cnt   <= '0;
          end else if (burst_cnt == BURST_W'(BURST_LEN)) begin
            state     <= ST_GAP;
            burst_cnt <= '0;
            gap_cnt   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (!bus.ON) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            gap_cnt   <= '0;
          end else if (gap_cnt == GAP_BITS'(GAP_CYCLES - 1)) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.SPI_ENA   = spi_ena;
  assign bus.SPI_DATA  = spi_data;
  assign bus.CH_RDREQ  = ch_rdreq;
  assign bus.GRANT_CH  = grant_ch;
  assign bus.BUSY      = busy;
  assign bus.WORD_DONE = word_done;

endmodule

// File: tb/tb_uc_channel_arbiter.sv
// tb/tb_uc_channel_arbiter.sv - directed self-checking bench for uc_channel_arbiter
module tb_uc_channel_arbiter;

  logic SYS_CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;
  int   n;

  localparam logic [15:0] D0 = 16'hA0F0;
  localparam logic [15:0] D1 = 16'h1234;
  localparam logic [15:0] D2 = 16'hC2C2;
  localparam logic [15:0] D3 = 16'hD3D3;

  uc_channel_arbiter_if #(.NUM_CH(4), .CH_BITS(2)) bus ();

  uc_channel_arbiter #(
    .NUM_CH     (4),
    .CH_BITS    (2),
    .TICK_BITS  (4),
    .BURST_LEN  (3),
    .GAP_CYCLES (100),
    .GAP_BITS   (17)
  ) dut (
    .SYS_CLK (SYS_CLK),
    .RST     (RST),
    .bus     (bus)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  function automatic logic [15:0] exp_word(input int ch);
    logic [15:0] w;
    logic [1:0]  c2;
    c2 = 2'(ch);
    case (ch)
      0:       w = D0;
      1:       w = D1;
      2:       w = D2;
      default: w = D3;
    endcase
`ifdef UC_ARB_TAG_EN
    w = {c2, w[13:0]};
`endif
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge SYS_CLK);
    @(negedge SYS_CLK);
  endtask

  task automatic wait_ena(input int max, output int cnt);
    cnt = 0;
    while (cnt < max) begin
      cyc();
      cnt++;
      if (bus.SPI_ENA === 1'b1) break;
    end
  endtask

  task automatic expect_grant(input string tag, input int ch);
    int w;
    wait_ena(40, w);
    check({tag, "_ena"}, 32'(bus.SPI_ENA), 1);
    check({tag, "_ch"}, 32'(bus.GRANT_CH), ch);
    check({tag, "_data"}, 32'(bus.SPI_DATA), 32'(exp_word(ch)));
  endtask

  task automatic do_fin(input string tag, input int ch);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    bus.SPI_FIN = 1'b1;
    cyc();
    check({tag, "_pop_rdreq"}, 32'(bus.CH_RDREQ), 32'(oh));
    check({tag, "_pop_done"}, 32'(bus.WORD_DONE), 1);
    check({tag, "_pop_ena"}, 32'(bus.SPI_ENA), 0);
    bus.SPI_FIN = 1'b0;
    cyc();
    check({tag, "_post_rdreq"}, 32'(bus.CH_RDREQ), 0);
    check({tag, "_post_done"}, 32'(bus.WORD_DONE), 0);
    check({tag, "_post_ena"}, 32'(bus.SPI_ENA), 0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int hits;
    hits = 0;
    repeat (cycles) begin
      cyc();
      if (bus.SPI_ENA !== 1'b0) hits++;
    end
    check(tag, hits, 0);
  endtask

  initial begin
    RST          = 1'b1;
    bus.ON       = 1'b0;
    bus.SPI_FIN  = 1'b0;
    bus.CH_EMPTY = 4'b1111;
    bus.CH_DATA  = {D3, D2, D1, D0};
    repeat (3) cyc();

    check("rst_ena", 32'(bus.SPI_ENA), 0);
    check("rst_data", 32'(bus.SPI_DATA), 0);
    check("rst_rdreq", 32'(bus.CH_RDREQ), 0);
    check("rst_grant", 32'(bus.GRANT_CH), 0);
    check("rst_busy", 32'(bus.BUSY), 0);
    check("rst_done", 32'(bus.WORD_DONE), 0);

    // single channel: counter runs 8 cycles to its MSB edge, grant registered one later
    bus.CH_EMPTY = 4'b1101;
    RST    = 1'b0;
    bus.ON = 1'b1;
    wait_ena(40, n);
    check("first_lat", n, 9);
    check("first_ch", 32'(bus.GRANT_CH), 1);
    check("first_data", 32'(bus.SPI_DATA), 32'(exp_word(1)));
    check("first_busy", 32'(bus.BUSY), 1);

    // FIFO drains and head changes mid-SEND: latched word must hold
    bus.CH_EMPTY       = 4'b1111;
    bus.CH_DATA[31:16] = 16'hFFFF;
    repeat (3) cyc();
    check("midsend_ena", 32'(bus.SPI_ENA), 1);
    check("midsend_data", 32'(bus.SPI_DATA), 32'(exp_word(1)));
    bus.CH_DATA  = {D3, D2, D1, D0};
    bus.CH_EMPTY = 4'b0101;
    do_fin("w1", 1);

    // ch0/ch2 empty: alternate 3,1; third pop enters the gap
    expect_grant("skip_a", 3);
    do_fin("skip_a", 3);
    expect_grant("skip_b", 1);
    do_fin("skip_b", 1);
    bus.CH_EMPTY = 4'b0000;
    quiet("gap_silent", 99);

    // after gap, rotation continues from last=1
    expect_grant("rr2", 2);
    do_fin("rr2", 2);
    expect_grant("rr3", 3);
    do_fin("rr3", 3);
    expect_grant("rr0", 0);
    do_fin("rr0", 0);

    // ON drop inside gap: immediate idle, tick counter restarts from zero
    repeat (5) cyc();
    bus.ON = 1'b0;
    repeat (2) cyc();
    bus.ON = 1'b1;
    wait_ena(40, n);
    check("gap_abort_lat", n, 9);
    check("gap_abort_ch", 32'(bus.GRANT_CH), 1);
    do_fin("ga1", 1);

    // ON drop mid-SEND: word completes and pops, then the block idles
    expect_grant("ondrop", 2);
    bus.ON = 1'b0;
    repeat (4) cyc();
    check("ondrop_ena_held", 32'(bus.SPI_ENA), 1);
    check("ondrop_busy_held", 32'(bus.BUSY), 1);
    do_fin("ondrop", 2);
    quiet("off_idle", 40);
    bus.ON = 1'b1;
    wait_ena(40, n);
    check("reon_lat", n, 9);
    check("reon_ch", 32'(bus.GRANT_CH), 3);
    do_fin("reon", 3);
    // burst counter was cleared while off, so no gap yet
    expect_grant("burst_clr", 0);

    // reset mid-SEND: no pop, same word resent at first tick after release
    RST = 1'b1;
    cyc();
    check("rstsend_ena", 32'(bus.SPI_ENA), 0);
    check("rstsend_rdreq", 32'(bus.CH_RDREQ), 0);
    check("rstsend_done", 32'(bus.WORD_DONE), 0);
    check("rstsend_busy", 32'(bus.BUSY), 0);
    RST = 1'b0;
    wait_ena(40, n);
    check("resend_lat", n, 9);
    check("resend_ch", 32'(bus.GRANT_CH), 0);
    check("resend_data", 32'(bus.SPI_DATA), 32'(exp_word(0)));
    do_fin("resend", 0);

    // lost opportunities: all empty, or FIN still high at tick
    bus.CH_EMPTY = 4'b1111;
    quiet("all_empty", 40);
    bus.CH_EMPTY = 4'b0000;
    bus.SPI_FIN  = 1'b1;
    quiet("fin_high", 40);
    bus.SPI_FIN  = 1'b0;
    expect_grant("fin_low", 1);
    do_fin("fin_low", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
